// File: rtl/hmac_arb_pkg.sv
// Shared types and default widths for the hmac arbiter slice.
package hmac_arb_pkg;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Start = 2'd1,
    Wait  = 2'd2,
    Resp  = 2'd3
  } state_e;

  localparam int MSG_W  = 512;
  localparam int KEY_W  = 256;
  localparam int HASH_W = 256;

endpackage

// File: rtl/hmac_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod N.
// Wrap is done with an explicit compare so non-power-of-2 N works.
module hmac_rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Scan from farthest to nearest offset so the nearest valid request wins.
  always_comb begin
    valid  = |req;
    idx    = '0;
    onehot = '0;
    sum    = '0;
    cand   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
      cand = sum[IW-1:0];
      if (req[cand]) idx = cand;
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/hmac_arbiter.sv
// Shares one hmac engine between NumReq requesters: round-robin accept,
// latch job, pulse init, wait for hash (bounded by a timeout), return result.
//
// state | meaning
// Idle  | engine free, grant when a request is valid and engine ready
// Start | one-cycle init pulse to engine, timeout counter cleared
// Wait  | waiting for hash_valid or timeout
// Resp  | result presented to owner until it accepts
module hmac_arbiter
  import hmac_arb_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int MsgWidth      = MSG_W,
  parameter int KeyWidth      = KEY_W,
  parameter int HashWidth     = HASH_W,
  parameter int TimeoutCycles = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*MsgWidth-1:0]   req_msg_i,
  input  logic [NumReq*KeyWidth-1:0]   req_key_i,
  output logic [NumReq-1:0]            rsp_valid_o,
  input  logic [NumReq-1:0]            rsp_ready_i,
  output logic [HashWidth-1:0]         rsp_hash_o,
  output logic                         rsp_err_o,
  output logic                         busy_o,
  output logic                         hmac_init_o,
  output logic [KeyWidth-1:0]          hmac_key_o,
  output logic [MsgWidth-1:0]          hmac_msg_o,
  input  logic                         hmac_ready_i,
  input  logic [HashWidth-1:0]         hmac_hash_i,
  input  logic                         hmac_hash_valid_i
);

  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, grant_q;
  logic [MsgWidth-1:0] msg_q, msg_sel;
  logic [KeyWidth-1:0] key_q, key_sel;
  logic [HashWidth-1:0] hash_q;
  logic                err_q;
  logic [CntW-1:0]     cnt_q;

  logic                pick_valid;
  logic [IdxW-1:0]     pick_idx;
  logic [NumReq-1:0]   pick_onehot;
  logic                accept, done_hash, done_to, resp_ack;

  hmac_rr_pick #(.N(NumReq), .IW(IdxW)) u_pick (
    .req    (req_valid_i),
    .ptr    (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Select the winner's message and key for latching.
  always_comb begin
    msg_sel = '0;
    key_sel = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (pick_idx == IdxW'(i)) begin
        msg_sel = req_msg_i[i*MsgWidth +: MsgWidth];
        key_sel = req_key_i[i*KeyWidth +: KeyWidth];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= Idle;
    else       state_q <= state_d;
  end

  // Next state and outputs; hash_valid wins over timeout on the same cycle.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    done_hash   = 1'b0;
    done_to     = 1'b0;
    resp_ack    = 1'b0;
    req_ready_o = '0;
    rsp_valid_o = '0;
    case (state_q)
      Idle: begin
        if (pick_valid && hmac_ready_i && !rst_i) begin
          accept      = 1'b1;
          req_ready_o = pick_onehot;
          state_d     = Start;
        end
      end
      Start: state_d = Wait;
      Wait: begin
        if (hmac_hash_valid_i) begin
          done_hash = 1'b1;
          state_d   = Resp;
        end else if (cnt_q == CntLast) begin
          done_to = 1'b1;
          state_d = Resp;
        end
      end
      Resp: begin
        rsp_valid_o[grant_q] = 1'b1;
        if (rsp_ready_i[grant_q]) begin
          resp_ack = 1'b1;
          state_d  = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  // Job registers, timeout counter and round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      msg_q    <= '0;
      key_q    <= '0;
      hash_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        grant_q <= pick_idx;
        msg_q   <= msg_sel;
        key_q   <= key_sel;
      end
      if (state_q == Start)     cnt_q <= '0;
      else if (state_q == Wait) cnt_q <= cnt_q + CntW'(1);
      if (done_hash) begin
        hash_q <= hmac_hash_i;
        err_q  <= 1'b0;
      end else if (done_to) begin
        hash_q <= '0;
        err_q  <= 1'b1;
      end
      if (resp_ack)
        rr_ptr_q <= (grant_q == IdxW'(NumReq - 1)) ? '0 : grant_q + IdxW'(1);
    end
  end

  assign busy_o      = (state_q != Idle);
  assign hmac_init_o = (state_q == Start);
  assign hmac_key_o  = key_q;
  assign hmac_msg_o  = msg_q;
  // Result only visible while presenting so an old error never lingers.
  assign rsp_hash_o  = (state_q == Resp) ? hash_q : '0;
  assign rsp_err_o   = (state_q == Resp) & err_q;

endmodule

// File: tb/tb_hmac_arbiter.sv
// Directed bench for hmac_arbiter with a hand-driven engine.
module tb_hmac_arbiter;
  localparam int NumReq = 2, MsgWidth = 512, KeyWidth = 256, HashWidth = 256;
  localparam int TimeoutCycles = 16;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [NumReq-1:0] req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [NumReq*MsgWidth-1:0] req_msg_i;
  logic [NumReq*KeyWidth-1:0] req_key_i;
  logic [HashWidth-1:0] rsp_hash_o, hmac_hash_i;
  logic rsp_err_o, busy_o, hmac_init_o, hmac_ready_i, hmac_hash_valid_i;
  logic [KeyWidth-1:0] hmac_key_o;
  logic [MsgWidth-1:0] hmac_msg_o;

  int checks = 0;
  int errors = 0;

  logic [MsgWidth-1:0]  msg0, msg1;
  logic [KeyWidth-1:0]  key0, key1;
  logic [HashWidth-1:0] h_a5, hv;
  logic [NumReq-1:0]    exp_g;

  always #5 clk_i = ~clk_i;

  hmac_arbiter #(
    .NumReq(NumReq), .MsgWidth(MsgWidth), .KeyWidth(KeyWidth),
    .HashWidth(HashWidth), .TimeoutCycles(TimeoutCycles)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_msg_i(req_msg_i), .req_key_i(req_key_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_hash_o(rsp_hash_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
    .hmac_init_o(hmac_init_o), .hmac_key_o(hmac_key_o), .hmac_msg_o(hmac_msg_o),
    .hmac_ready_i(hmac_ready_i), .hmac_hash_i(hmac_hash_i),
    .hmac_hash_valid_i(hmac_hash_valid_i)
  );

  task automatic test_reset();
    rst_i = 1'b1; req_valid_i = 2'b11; rsp_ready_i = '0; hmac_ready_i = 1'b1;
    hmac_hash_i = '0; hmac_hash_valid_i = 1'b0;
    req_msg_i = {msg1, msg0}; req_key_i = {key1, key0};
    @(negedge clk_i); #1;
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (rsp_valid_o !== 2'b00 || hmac_init_o !== 1'b0 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got rsp_valid=%b init=%b err=%b expected 00/0/0", rsp_valid_o, hmac_init_o, rsp_err_o); end
    checks++; if (hmac_msg_o !== '0 || hmac_key_o !== '0 || rsp_hash_o !== '0) begin errors++; $display("FAIL reset_data: got nonzero msg/key/hash expected 0"); end
    req_valid_i = '0;
    @(negedge clk_i); rst_i = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk_i); req_valid_i = 2'b01; #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL single_accept: got %b expected 01", req_ready_o); end
    @(negedge clk_i); req_valid_i = 2'b00; #1;
    checks++; if (hmac_init_o !== 1'b1) begin errors++; $display("FAIL single_init: got %b expected 1", hmac_init_o); end
    checks++; if (hmac_msg_o !== msg0 || hmac_key_o !== key0) begin errors++; $display("FAIL single_latch: got msg=%h key=%h expected req0 data", hmac_msg_o, hmac_key_o); end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i); #1;
      checks++; if (hmac_init_o !== 1'b0 || rsp_valid_o !== 2'b00) begin errors++; $display("FAIL single_wait%0d: got init=%b rsp_valid=%b expected 0/00", i, hmac_init_o, rsp_valid_o); end
    end
    @(negedge clk_i); hmac_hash_valid_i = 1'b1; hmac_hash_i = h_a5;
    @(negedge clk_i); hmac_hash_valid_i = 1'b0; hmac_hash_i = '0; #1;
    checks++; if (rsp_valid_o !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b expected 01", rsp_valid_o); end
    checks++; if (rsp_hash_o !== h_a5 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL single_rsp_data: got hash=%h err=%b expected a5..a5/0", rsp_hash_o, rsp_err_o); end
    rsp_ready_i = 2'b01;
    @(negedge clk_i); rsp_ready_i = 2'b00; #1;
    checks++; if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin errors++; $display("FAIL single_done: got rsp_valid=%b busy=%b expected 00/0", rsp_valid_o, busy_o); end
  endtask

  task automatic test_round_robin();
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0; req_valid_i = 2'b11;
    for (int j = 0; j < 4; j++) begin
      exp_g = (j % 2 == 1) ? 2'b10 : 2'b01;
      hv = {8{32'hABC0_0000 | 32'(j)}};
      #1;
      checks++; if (req_ready_o !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", j, req_ready_o, exp_g); end
      @(negedge clk_i); #1;
      checks++; if (hmac_init_o !== 1'b1 || hmac_msg_o !== ((j % 2 == 1) ? msg1 : msg0)) begin errors++; $display("FAIL rr_start%0d: got init=%b msg=%h", j, hmac_init_o, hmac_msg_o); end
      @(negedge clk_i); hmac_hash_valid_i = 1'b1; hmac_hash_i = hv;
      @(negedge clk_i); hmac_hash_valid_i = 1'b0; #1;
      checks++; if (rsp_valid_o !== exp_g || rsp_hash_o !== hv || req_ready_o !== 2'b00) begin errors++; $display("FAIL rr_rsp%0d: got rsp_valid=%b hash=%h req_ready=%b expected %b", j, rsp_valid_o, rsp_hash_o, req_ready_o, exp_g); end
      rsp_ready_i = exp_g;
      @(negedge clk_i); rsp_ready_i = 2'b00;
    end
    req_valid_i = 2'b00;
  endtask

  task automatic test_timeout();
    @(negedge clk_i); req_valid_i = 2'b01; #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL to_accept: got %b expected 01", req_ready_o); end
    @(negedge clk_i); req_valid_i = 2'b00; #1;
    checks++; if (hmac_init_o !== 1'b1) begin errors++; $display("FAIL to_init: got %b expected 1", hmac_init_o); end
    for (int i = 0; i < TimeoutCycles; i++) begin
      @(negedge clk_i); #1;
      checks++; if (rsp_valid_o !== 2'b00 || busy_o !== 1'b1) begin errors++; $display("FAIL to_wait%0d: got rsp_valid=%b busy=%b expected 00/1", i, rsp_valid_o, busy_o); end
    end
    @(negedge clk_i); #1;
    checks++; if (rsp_valid_o !== 2'b01 || rsp_err_o !== 1'b1 || rsp_hash_o !== '0) begin errors++; $display("FAIL to_rsp: got rsp_valid=%b err=%b hash=%h expected 01/1/0", rsp_valid_o, rsp_err_o, rsp_hash_o); end
    hmac_hash_valid_i = 1'b1; hmac_hash_i = h_a5;
    @(negedge clk_i); hmac_hash_valid_i = 1'b0; #1;
    checks++; if (rsp_err_o !== 1'b1 || rsp_hash_o !== '0) begin errors++; $display("FAIL to_late_hash: got err=%b hash=%h expected 1/0", rsp_err_o, rsp_hash_o); end
    rsp_ready_i = 2'b01;
    @(negedge clk_i); rsp_ready_i = 2'b00; hmac_hash_valid_i = 1'b1; #1;
    checks++; if (busy_o !== 1'b0 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL to_idle: got busy=%b err=%b expected 0/0", busy_o, rsp_err_o); end
    @(negedge clk_i); hmac_hash_valid_i = 1'b0; #1;
    checks++; if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin errors++; $display("FAIL to_idle_hash: got rsp_valid=%b busy=%b expected 00/0", rsp_valid_o, busy_o); end
  endtask

  task automatic test_ready_low();
    @(negedge clk_i); hmac_ready_i = 1'b0; req_valid_i = 2'b10; #1;
    checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL rl_no_accept: got %b expected 00", req_ready_o); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); #1;
      checks++; if (req_ready_o !== 2'b00 || hmac_init_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rl_hold%0d: got req_ready=%b init=%b busy=%b expected 00/0/0", i, req_ready_o, hmac_init_o, busy_o); end
    end
    @(negedge clk_i); hmac_ready_i = 1'b1; #1;
    checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL rl_accept: got %b expected 10", req_ready_o); end
    @(negedge clk_i); req_valid_i = 2'b00; #1;
    checks++; if (hmac_init_o !== 1'b1 || hmac_msg_o !== msg1 || hmac_key_o !== key1) begin errors++; $display("FAIL rl_start: got init=%b msg=%h key=%h expected req1 data", hmac_init_o, hmac_msg_o, hmac_key_o); end
    hv = {8{32'h4444_4444}};
    @(negedge clk_i); hmac_hash_valid_i = 1'b1; hmac_hash_i = hv;
    @(negedge clk_i); hmac_hash_valid_i = 1'b0; #1;
    checks++; if (rsp_valid_o !== 2'b10 || rsp_hash_o !== hv) begin errors++; $display("FAIL rl_rsp: got rsp_valid=%b hash=%h expected 10", rsp_valid_o, rsp_hash_o); end
    rsp_ready_i = 2'b10;
    @(negedge clk_i); rsp_ready_i = 2'b00;
  endtask

  task automatic test_reset_mid_job();
    @(negedge clk_i); req_valid_i = 2'b01; #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL rm_accept: got %b expected 01", req_ready_o); end
    @(negedge clk_i); req_valid_i = 2'b00;
    @(negedge clk_i);
    @(negedge clk_i); rst_i = 1'b1; #1;
    checks++; if (busy_o !== 1'b0 || hmac_init_o !== 1'b0 || rsp_valid_o !== 2'b00 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL rm_ctrl: got busy=%b init=%b rsp_valid=%b err=%b expected all 0", busy_o, hmac_init_o, rsp_valid_o, rsp_err_o); end
    checks++; if (hmac_msg_o !== '0 || hmac_key_o !== '0 || rsp_hash_o !== '0) begin errors++; $display("FAIL rm_data: got nonzero msg/key/hash expected 0"); end
    @(negedge clk_i); rst_i = 1'b0; hmac_hash_valid_i = 1'b1; hmac_hash_i = h_a5;
    @(negedge clk_i); hmac_hash_valid_i = 1'b0; #1;
    checks++; if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin errors++; $display("FAIL rm_stale1: got rsp_valid=%b busy=%b expected 00/0", rsp_valid_o, busy_o); end
    @(negedge clk_i); #1;
    checks++; if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin errors++; $display("FAIL rm_stale2: got rsp_valid=%b busy=%b expected 00/0", rsp_valid_o, busy_o); end
  endtask

  task automatic test_resp_hold();
    hv = {8{32'h6666_1234}};
    @(negedge clk_i); req_valid_i = 2'b01; #1;
    checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL rh_accept: got %b expected 01", req_ready_o); end
    @(negedge clk_i); req_valid_i = 2'b10; #1;
    checks++; if (hmac_init_o !== 1'b1 || req_ready_o !== 2'b00) begin errors++; $display("FAIL rh_start: got init=%b req_ready=%b expected 1/00", hmac_init_o, req_ready_o); end
    @(negedge clk_i); hmac_hash_valid_i = 1'b1; hmac_hash_i = hv;
    @(negedge clk_i); hmac_hash_valid_i = 1'b0; hmac_hash_i = '0; rsp_ready_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rsp_valid_o !== 2'b01 || rsp_hash_o !== hv || rsp_err_o !== 1'b0 || req_ready_o !== 2'b00) begin errors++; $display("FAIL rh_hold%0d: got rsp_valid=%b hash=%h err=%b req_ready=%b", i, rsp_valid_o, rsp_hash_o, rsp_err_o, req_ready_o); end
      @(negedge clk_i);
    end
    rsp_ready_i = 2'b01; #1;
    checks++; if (rsp_valid_o !== 2'b01) begin errors++; $display("FAIL rh_pre_ack: got %b expected 01", rsp_valid_o); end
    @(negedge clk_i); rsp_ready_i = 2'b00; #1;
    checks++; if (req_ready_o !== 2'b10 || busy_o !== 1'b0) begin errors++; $display("FAIL rh_next_accept: got req_ready=%b busy=%b expected 10/0", req_ready_o, busy_o); end
    req_valid_i = 2'b00;
    @(negedge clk_i);
  endtask

  initial begin
    msg0 = {16{32'hDEAD_0000}};
    msg1 = {16{32'hBEEF_1111}};
    key0 = {8{32'hC0DE_0000}};
    key1 = {8{32'hC0DE_1111}};
    h_a5 = {32{8'hA5}};
    hv   = '0;
    exp_g = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_ready_low();
    test_reset_mid_job();
    test_resp_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
